deserializer_align: RTL

DESERIALIZER_ALIGN -- requirements
Module: deserializer_align

---
 rtl/serdes_pkg.sv | 19 +
 rtl/comma_detect.sv | 20 ++
 rtl/deserializer_align.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// serdes_pkg: comma symbols, alignment states and default word width shared by
// the serializer and deserializer.                              Rev 1.0
////////////////////////////////////////////////////////////////////////////////
package serdes_pkg;

  localparam int         DEFAULT_WIDTH = 10;
  localparam logic [9:0] COMMA_P       = 10'b0011111010;
  localparam logic [9:0] COMMA_N       = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

endpackage
`default_nettype wire

// File: rtl/comma_detect.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// comma_detect: flags a window equal to either comma polarity.
//                                                               Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module comma_detect
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_window,
  output logic             o_comma
);

  always_comb begin
    o_comma = (i_window == WIDTH'(COMMA_P)) || (i_window == WIDTH'(COMMA_N));
  end

endmodule
`default_nettype wire

// File: rtl/deserializer_align.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// deserializer_align: serial-to-parallel conversion with comma-based word
// boundary acquisition, verification and loss-of-lock tracking. Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module deserializer_align
  import serdes_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             is_comma,
  output logic             locked
);

  localparam int PH_W   = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  logic [WIDTH-2:0]  sr_q, sr_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  align_state_e      state_q, state_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              is_comma_q, is_comma_d;
  logic              locked_q, locked_d;

  logic [WIDTH-1:0]  w_window;
  logic              w_comma;
  logic              w_boundary;

  assign w_window   = {sr_q, data_in};
  assign w_boundary = (phase_q == PH_W'(WIDTH - 1));

  comma_detect #(.WIDTH(WIDTH)) u_comma_detect (
    .i_window (w_window),
    .o_comma  (w_comma)
  );

  always_comb begin
    sr_d       = sr_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    state_d    = state_q;
    data_out_d = data_out_q;
    is_comma_d = is_comma_q;
    valid_d    = 1'b0;

    if (enable) begin
      sr_d    = w_window[WIDTH-2:0];
      phase_d = w_boundary ? '0 : phase_q + PH_W'(1);

      case (state_q)
        ST_HUNT: begin
          if (w_comma) begin
            phase_d = '0;
            cnt_d   = CNT_W'(1);
            state_d = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (w_comma && w_boundary) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (w_comma) begin
            // Off-boundary comma restarts verification at its own alignment
            phase_d = '0;
            cnt_d   = CNT_W'(1);
          end
        end

        ST_LOCKED: begin
          if (w_boundary) begin
            valid_d    = 1'b1;
            data_out_d = w_window;
            is_comma_d = w_comma;
          end
          if (w_comma && w_boundary) begin
            miss_d = '0;
          end else if (w_comma) begin
            miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(LOSS_CNT)) begin
              state_d = ST_HUNT;
              miss_d  = '0;
              cnt_d   = '0;
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      state_q    <= ST_HUNT;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      is_comma_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      is_comma_q <= is_comma_d;
      locked_q   <= locked_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign is_comma = is_comma_q;
  assign locked   = locked_q;

endmodule
`default_nettype wire
